// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory pins of the load/store unit.
// slave = the unit's view; master = requester plus memory.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_misaligned;
    logic              mem_read_en;
    logic              mem_write_en;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_misaligned,
               mem_read_en, mem_write_en, mem_address, mem_write_data
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned,
               mem_read_en, mem_write_en, mem_address, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Sub-word load/store front end for a word-addressed data memory; SB/SH use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning them.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    // state     | meaning
    // IDLE      | waiting for a request, req_ready high
    // LOAD      | memory read, selected lane extended into the response
    // STORE     | full-word write of the store data
    // RMW_READ  | read the old word for SB/SH
    // RMW_WRITE | write the old word with one byte/half replaced
    // FAULT     | misaligned access, respond without touching memory

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        STORE     = 3'd2,
        RMW_READ  = 3'd3,
        RMW_WRITE = 3'd4,
        FAULT     = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_old_word;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_misaligned;

    logic              w_accept;
    logic              w_req_is_word;
    logic              w_req_is_half;
    logic              w_misaligned;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merged_word;
    logic              w_rd_en;
    logic              w_wr_en;
    logic [31:0]       w_wr_data;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_resp_valid;
    logic [31:0]       w_resp_rdata;
    logic              w_resp_misaligned;

    assign w_accept      = bus.req_valid && (r_state == IDLE);
    assign w_req_is_word = bus.req_funct3[1];
    assign w_req_is_half = (bus.req_funct3[1:0] == 2'b01);
    assign w_misaligned  = TRAP_EN &&
                           ((w_req_is_half && bus.req_addr[0]) ||
                            (w_req_is_word && (bus.req_addr[1:0] != 2'b00)));

    // Load lane select and extension; the word case ignores the low address bits.
    always_comb begin
        w_byte      = 8'h00;
        w_load_data = bus.mem_read_data;
        case (r_addr[1:0])
            2'd0: w_byte = bus.mem_read_data[7:0];
            2'd1: w_byte = bus.mem_read_data[15:8];
            2'd2: w_byte = bus.mem_read_data[23:16];
            2'd3: w_byte = bus.mem_read_data[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = r_addr[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
        case (r_funct3[1:0])
            2'b00:   w_load_data = r_funct3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_data = r_funct3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_data = bus.mem_read_data;
        endcase
    end

    // Only byte and half stores reach RMW, so anything that is not a byte is a half.
    always_comb begin
        w_merged_word = r_old_word;
        if (r_funct3[1:0] == 2'b00) begin
            case (r_addr[1:0])
                2'd0: w_merged_word[7:0]   = r_wdata[7:0];
                2'd1: w_merged_word[15:8]  = r_wdata[7:0];
                2'd2: w_merged_word[23:16] = r_wdata[7:0];
                2'd3: w_merged_word[31:24] = r_wdata[7:0];
                default: w_merged_word = r_old_word;
            endcase
        end else if (r_addr[1]) begin
            w_merged_word[31:16] = r_wdata[15:0];
        end else begin
            w_merged_word[15:0] = r_wdata[15:0];
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_rd_en           = 1'b0;
        w_wr_en           = 1'b0;
        w_wr_data         = 32'h0;
        w_resp_valid      = 1'b0;
        w_resp_rdata      = 32'h0;
        w_resp_misaligned = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (w_misaligned)       w_next_state = FAULT;
                    else if (!bus.req_write) w_next_state = LOAD;
                    else if (w_req_is_word)  w_next_state = STORE;
                    else                     w_next_state = RMW_READ;
                end
            end
            LOAD: begin
                w_rd_en      = 1'b1;
                w_resp_valid = 1'b1;
                w_resp_rdata = w_load_data;
                w_next_state = IDLE;
            end
            STORE: begin
                w_wr_en      = 1'b1;
                w_wr_data    = r_wdata;
                w_resp_valid = 1'b1;
                w_next_state = IDLE;
            end
            RMW_READ: begin
                w_rd_en      = 1'b1;
                w_next_state = RMW_WRITE;
            end
            RMW_WRITE: begin
                w_wr_en      = 1'b1;
                w_wr_data    = w_merged_word;
                w_resp_valid = 1'b1;
                w_next_state = IDLE;
            end
            FAULT: begin
                w_resp_valid      = 1'b1;
                w_resp_misaligned = 1'b1;
                w_next_state      = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_mem_addr = (w_rd_en || w_wr_en) ? {r_addr[ADDR_W-1:2], 2'b00} : '0;

    // Reset masks the memory pins in the same cycle so an aborted RMW never writes.
    assign bus.mem_read_en     = w_rd_en && !rst;
    assign bus.mem_write_en    = w_wr_en && !rst;
    assign bus.mem_address     = rst ? '0 : w_mem_addr;
    assign bus.mem_write_data  = rst ? 32'h0 : w_wr_data;
    assign bus.req_ready       = (r_state == IDLE);
    assign bus.resp_valid      = r_resp_valid;
    assign bus.resp_rdata      = r_resp_rdata;
    assign bus.resp_misaligned = TRAP_EN && r_resp_misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= IDLE;
            r_funct3          <= 3'b000;
            r_addr            <= '0;
            r_wdata           <= 32'h0;
            r_old_word        <= 32'h0;
            r_resp_valid      <= 1'b0;
            r_resp_rdata      <= 32'h0;
            r_resp_misaligned <= 1'b0;
        end else begin
            r_state           <= w_next_state;
            r_resp_valid      <= w_resp_valid;
            r_resp_rdata      <= w_resp_rdata;
            r_resp_misaligned <= w_resp_misaligned;
            if (w_accept) begin
                r_funct3 <= bus.req_funct3;
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
            end
            if (r_state == RMW_READ) begin
                r_old_word <= bus.mem_read_data;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: 64-word memory, timeline reference model, per-cycle compare.
// Follows LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_load_store_unit;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam int K_LOAD  = 0;
    localparam int K_SW    = 1;
    localparam int K_RMW   = 2;
    localparam int K_FAULT = 3;

    typedef struct {
        int          kind;
        int          last;
        logic [5:0]  idx;
        logic [31:0] word;
        logic [31:0] rdata;
        logic        mis;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(32)) bus ();
    load_store_unit #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic chk_en  = 1'b0;
    logic preload = 1'b1;
    logic [31:0] init_mem [64];
    logic [31:0] tb_mem   [64];
    logic [31:0] ref_mem  [64];
    logic [31:0] last_rdata = 32'h0;
    logic        last_mis   = 1'b0;

    // memory behind the DUT
    assign bus.mem_read_data = tb_mem[bus.mem_address[7:2]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= init_mem[i];
        end else if (bus.mem_write_en) begin
            tb_mem[bus.mem_address[7:2]] <= bus.mem_write_data;
        end
    end

    function automatic logic f_trap(input logic [2:0] f3, input logic [7:0] a);
        return TRAP && (((f3[1:0] == 2'b01) && a[0]) || (f3[1] && (a[1:0] != 2'b00)));
    endfunction

    function automatic logic [31:0] f_load(input logic [31:0] w, input logic [2:0] f3, input logic [7:0] a);
        int sh;
        logic [31:0] v;
        if (f3[1]) return w;
        if (f3[1:0] == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            v = (w >> sh) & 32'hFF;
            if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else begin
            sh = 16 * int'(a[1]);
            v = (w >> sh) & 32'hFFFF;
            if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [2:0] f3,
                                            input logic [7:0] a, input logic [31:0] wd);
        int sh;
        logic [31:0] mask;
        if (f3[1:0] == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            mask = 32'hFF << sh;
        end else begin
            sh = 16 * int'(a[1]);
            mask = 32'hFFFF << sh;
        end
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    function automatic op_t f_accept(input logic w, input logic [2:0] f3, input logic [7:0] a,
                                     input logic [31:0] wd, input logic [31:0] old);
        op_t o;
        o.idx = a[7:2];
        o.word = 32'h0;
        o.rdata = 32'h0;
        o.mis = 1'b0;
        if (f_trap(f3, a)) begin
            o.kind = K_FAULT;
            o.mis = 1'b1;
        end else if (!w) begin
            o.kind = K_LOAD;
            o.rdata = f_load(old, f3, a);
        end else if (f3[1]) begin
            o.kind = K_SW;
            o.word = wd;
        end else begin
            o.kind = K_RMW;
            o.word = f_merge(old, f3, a, wd);
        end
        o.last = (o.kind == K_RMW) ? 2 : 1;
        return o;
    endfunction

    // Reference model: one op in flight, d counts cycles since its accept edge.
    logic m_active = 1'b0;
    int   m_d = 0;
    op_t  m_op;
    logic m_ready, m_re_phase, m_we_phase, m_resp_phase;
    assign m_ready      = !m_active || (m_d == m_op.last);
    assign m_re_phase   = m_active && (m_d == 0) && ((m_op.kind == K_LOAD) || (m_op.kind == K_RMW));
    assign m_we_phase   = m_active && (((m_op.kind == K_SW) && (m_d == 0)) || ((m_op.kind == K_RMW) && (m_d == 1)));
    assign m_resp_phase = m_active && (m_d == m_op.last);

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) ref_mem[i] <= init_mem[i];
        end
        if (rst) begin
            m_active <= 1'b0;
        end else begin
            if (m_active) begin
                if (m_we_phase) ref_mem[m_op.idx] <= m_op.word;
                if (m_d == m_op.last) m_active <= 1'b0;
                m_d <= m_d + 1;
            end
            if (m_ready && bus.req_valid) begin
                m_active <= 1'b1;
                m_d <= 0;
                m_op <= f_accept(bus.req_write, bus.req_funct3, bus.req_addr[7:0],
                                 bus.req_wdata, ref_mem[bus.req_addr[7:2]]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        logic e_re, e_we;
        e_re = m_re_phase && !rst;
        e_we = m_we_phase && !rst;
        chk("req_ready", {31'h0, bus.req_ready}, {31'h0, m_ready});
        chk("resp_valid", {31'h0, bus.resp_valid}, {31'h0, m_resp_phase});
        chk("resp_rdata", bus.resp_rdata, m_resp_phase ? m_op.rdata : 32'h0);
        chk("resp_misaligned", {31'h0, bus.resp_misaligned}, {31'h0, m_resp_phase && m_op.mis});
        chk("mem_read_en", {31'h0, bus.mem_read_en}, {31'h0, e_re});
        chk("mem_write_en", {31'h0, bus.mem_write_en}, {31'h0, e_we});
        if (!rst) begin
            chk("mem_address", bus.mem_address, (e_re || e_we) ? {24'h0, m_op.idx, 2'b00} : 32'h0);
            chk("mem_write_data", bus.mem_write_data, e_we ? m_op.word : 32'h0);
        end
        if (bus.resp_valid) begin
            last_rdata = bus.resp_rdata;
            last_mis   = bus.resp_misaligned;
        end
    endtask

    always @(negedge clk) if (chk_en) compare_cycle();

    // Called just after a rising edge; returns just after the accept edge.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd);
        logic rdy;
        logic done;
        done = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = {24'h0, a};
        bus.req_wdata  = wd;
        for (int i = 0; i < 16 && !done; i++) begin
            rdy = m_ready;
            @(posedge clk);
            #1;
            done = rdy;
        end
        bus.req_valid = 1'b0;
        chk("req_accepted", {31'h0, done}, 32'h1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 8 && m_active; i++) begin
            @(posedge clk);
            #1;
        end
        chk("op_drained", {31'h0, m_active}, 32'h0);
    endtask

    task automatic run_random(input int n);
        logic       w;
        logic [2:0] f3;
        logic [7:0] a;
        logic [31:0] wd;
        for (int k = 0; k < n; k++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 8'($urandom_range(0, 255));
            wd = $urandom;
            do_req(w, f3, a, wd);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) init_mem[i] = $urandom;
        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        @(posedge clk);
        #1;
        preload = 1'b0;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("reset_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("reset_resp_rdata", bus.resp_rdata, 32'h0);
        chk("reset_resp_mis", {31'h0, bus.resp_misaligned}, 32'h0);

        // SW then LW back-to-back
        do_req(1'b1, 3'b010, 8'h10, 32'hDEAD_BEEF);
        do_req(1'b0, 3'b010, 8'h10, 32'h0);
        wait_done();
        chk("lw_after_sw", last_rdata, 32'hDEAD_BEEF);
        chk("mem_0x10", tb_mem[4], 32'hDEAD_BEEF);

        // SB RMW, with a held request whose fields change before acceptance
        do_req(1'b1, 3'b010, 8'h20, 32'h1122_3344);
        do_req(1'b1, 3'b000, 8'h22, 32'h0000_00AB);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h44;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        do_req(1'b0, 3'b010, 8'h20, 32'h0);
        wait_done();
        chk("sb_mem_0x20", tb_mem[8], 32'h11AB_3344);
        chk("held_lw_0x20", last_rdata, 32'h11AB_3344);

        // extension cases
        do_req(1'b1, 3'b010, 8'h30, 32'h80FF_7F01);
        do_req(1'b0, 3'b000, 8'h33, 32'h0);
        wait_done();
        chk("lb_0x33", last_rdata, 32'hFFFF_FF80);
        do_req(1'b0, 3'b100, 8'h33, 32'h0);
        wait_done();
        chk("lbu_0x33", last_rdata, 32'h0000_0080);
        do_req(1'b0, 3'b001, 8'h30, 32'h0);
        wait_done();
        chk("lh_0x30", last_rdata, 32'h0000_7F01);
        do_req(1'b0, 3'b101, 8'h32, 32'h0);
        wait_done();
        chk("lhu_0x32", last_rdata, 32'h0000_80FF);

        // misaligned SH
        do_req(1'b1, 3'b010, 8'h20, 32'h1122_3344);
        do_req(1'b1, 3'b001, 8'h21, 32'h0000_BEEF);
        wait_done();
`ifdef LSU_MISALIGN_TRAP_EN
        chk("sh_0x21_mis", {31'h0, last_mis}, 32'h1);
        chk("sh_0x21_rdata", last_rdata, 32'h0);
        chk("sh_0x21_mem", tb_mem[8], 32'h1122_3344);
`else
        chk("sh_0x21_mis", {31'h0, last_mis}, 32'h0);
        chk("sh_0x21_mem", tb_mem[8], 32'h1122_BEEF);
`endif

        // reset during RMW_WRITE of an SB
        do_req(1'b1, 3'b010, 8'h20, 32'h1122_3344);
        do_req(1'b1, 3'b000, 8'h21, 32'h0000_0055);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("abort_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("abort_mem_0x20", tb_mem[8], 32'h1122_3344);

        run_random(400);
        wait_done();
        for (int i = 0; i < 64; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
